prbs31_lock_checker: RTL and testbench

PRBS31_LOCK_CHECKER -- requirements
Module: prbs31_lock_checker

---
 rtl/prbs31_lock_checker.sv | 219 +++++++++++++++++++++
 tb/tb_prbs31_lock_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_lock_checker.sv
// PRBS31 (x^31 + x^28 + 1) lock checker.
// The checker seeds its predictor from the incoming stream and then hunts for
// LOCK_COUNT consecutive correct predictions. Once locked, it free-runs its own
// predictor and counts bit errors. Too many errors inside one monitoring window
// drop it back to SEED.
// Optional feature: define PRBS_LOCK_CHECKER_ERR_POS_EN to add last_error_pos,
// which holds the total_bits position of the most recent counted error.
module prbs31_lock_checker #(
    parameter int unsigned LOCK_COUNT  = 64,
    parameter int unsigned LOSS_WINDOW = 128,
    parameter int unsigned LOSS_ERRORS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    input  logic        data_in_valid,
    output logic        locked,
    output logic [31:0] total_bits,
    output logic [31:0] total_bit_errors,
    output logic [15:0] relock_count,
    output logic        error_pulse
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
    ,
    output logic [31:0] last_error_pos
`endif
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(LOSS_WINDOW + 1);
    localparam int EW = $clog2(LOSS_ERRORS + 1);

    localparam logic [MW-1:0] MATCH_ZERO = {MW{1'b0}};
    localparam logic [MW-1:0] MATCH_ONE  = MW'(1'b1);
    localparam logic [MW-1:0] MATCH_TGT  = MW'(LOCK_COUNT);
    localparam logic [WW-1:0] WIN_ZERO   = {WW{1'b0}};
    localparam logic [WW-1:0] WIN_ONE    = WW'(1'b1);
    localparam logic [WW-1:0] WIN_TGT    = WW'(LOSS_WINDOW);
    localparam logic [EW-1:0] ERR_ZERO   = {EW{1'b0}};
    localparam logic [EW-1:0] ERR_ONE    = EW'(1'b1);
    localparam logic [EW-1:0] ERR_TGT    = EW'(LOSS_ERRORS);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Next PRBS31 bit predicted from the current 31-bit state.
    function automatic logic prbs31_pred(input logic [30:0] st);
        return st[30] ^ st[27];
    endfunction

    // 32-bit increment that sticks at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    state_t        state_r, state_n;
    logic [30:0]   s_r, s_n;
    logic [4:0]    seed_cnt_r, seed_cnt_n;
    logic [MW-1:0] match_cnt_r, match_cnt_n, match_inc_s;
    logic [WW-1:0] win_cnt_r, win_cnt_n, win_inc_s;
    logic [EW-1:0] win_err_r, win_err_n, err_inc_s;
    logic          locked_r, locked_n;
    logic [31:0]   total_bits_r, total_bits_n;
    logic [31:0]   total_err_r, total_err_n;
    logic [15:0]   relock_r, relock_n;
    logic          error_pulse_r, error_pulse_n;
    logic          pred_s;
    logic          mismatch_s;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
    logic [31:0]   last_pos_r, last_pos_n;
`endif

    // Prediction, saturating increments and next-state decode for one valid bit.
    always_comb begin
        pred_s        = prbs31_pred(s_r);
        mismatch_s    = data_in ^ pred_s;
        match_inc_s   = (match_cnt_r == {MW{1'b1}}) ? match_cnt_r : (match_cnt_r + MATCH_ONE);
        win_inc_s     = (win_cnt_r == {WW{1'b1}}) ? win_cnt_r : (win_cnt_r + WIN_ONE);
        err_inc_s     = (win_err_r == {EW{1'b1}}) ? win_err_r : (win_err_r + ERR_ONE);

        state_n       = state_r;
        s_n           = s_r;
        seed_cnt_n    = seed_cnt_r;
        match_cnt_n   = match_cnt_r;
        win_cnt_n     = win_cnt_r;
        win_err_n     = win_err_r;
        locked_n      = locked_r;
        total_bits_n  = total_bits_r;
        total_err_n   = total_err_r;
        relock_n      = relock_r;
        error_pulse_n = 1'b0;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
        last_pos_n    = last_pos_r;
`endif

        if (data_in_valid) begin
            case (state_r)
                ST_SEED: begin
                    s_n = {s_r[29:0], data_in};
                    if (seed_cnt_r == 5'd30) begin
                        seed_cnt_n  = 5'd0;
                        match_cnt_n = MATCH_ZERO;
                        state_n     = ST_HUNT;
                    end else begin
                        seed_cnt_n  = seed_cnt_r + 5'd1;
                    end
                end
                ST_HUNT: begin
                    // Self-synchronising: the received bit feeds the state.
                    s_n = {s_r[29:0], data_in};
                    if (mismatch_s) begin
                        match_cnt_n = MATCH_ZERO;
                    end else if (match_inc_s == MATCH_TGT) begin
                        match_cnt_n = MATCH_ZERO;
                        win_cnt_n   = WIN_ZERO;
                        win_err_n   = ERR_ZERO;
                        locked_n    = 1'b1;
                        state_n     = ST_LOCKED;
                    end else begin
                        match_cnt_n = match_inc_s;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so a bad bit cannot corrupt the state.
                    s_n          = {s_r[29:0], pred_s};
                    total_bits_n = sat_inc32(total_bits_r);
                    if (mismatch_s) begin
                        total_err_n   = sat_inc32(total_err_r);
                        error_pulse_n = 1'b1;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
                        last_pos_n    = total_bits_n;
`endif
                    end else begin
                        total_err_n   = total_err_r;
                    end
                    // Loss of lock wins over the end-of-window clear.
                    if (mismatch_s && (err_inc_s == ERR_TGT)) begin
                        state_n    = ST_SEED;
                        locked_n   = 1'b0;
                        s_n        = 31'd0;
                        seed_cnt_n = 5'd0;
                        win_cnt_n  = WIN_ZERO;
                        win_err_n  = ERR_ZERO;
                        relock_n   = sat_inc16(relock_r);
                    end else if (win_inc_s == WIN_TGT) begin
                        win_cnt_n  = WIN_ZERO;
                        win_err_n  = ERR_ZERO;
                    end else begin
                        win_cnt_n  = win_inc_s;
                        win_err_n  = mismatch_s ? err_inc_s : win_err_r;
                    end
                end
                default: begin
                    state_n     = ST_SEED;
                    locked_n    = 1'b0;
                    s_n         = 31'd0;
                    seed_cnt_n  = 5'd0;
                    match_cnt_n = MATCH_ZERO;
                    win_cnt_n   = WIN_ZERO;
                    win_err_n   = ERR_ZERO;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State and statistics registers; reset clears everything including relock_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_SEED;
            s_r           <= 31'd0;
            seed_cnt_r    <= 5'd0;
            match_cnt_r   <= MATCH_ZERO;
            win_cnt_r     <= WIN_ZERO;
            win_err_r     <= ERR_ZERO;
            locked_r      <= 1'b0;
            total_bits_r  <= 32'd0;
            total_err_r   <= 32'd0;
            relock_r      <= 16'd0;
            error_pulse_r <= 1'b0;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
            last_pos_r    <= 32'd0;
`endif
        end else begin
            state_r       <= state_n;
            s_r           <= s_n;
            seed_cnt_r    <= seed_cnt_n;
            match_cnt_r   <= match_cnt_n;
            win_cnt_r     <= win_cnt_n;
            win_err_r     <= win_err_n;
            locked_r      <= locked_n;
            total_bits_r  <= total_bits_n;
            total_err_r   <= total_err_n;
            relock_r      <= relock_n;
            error_pulse_r <= error_pulse_n;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
            last_pos_r    <= last_pos_n;
`endif
        end
    end

    assign locked           = locked_r;
    assign total_bits       = total_bits_r;
    assign total_bit_errors = total_err_r;
    assign relock_count     = relock_r;
    assign error_pulse      = error_pulse_r;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
    assign last_error_pos   = last_pos_r;
`endif

endmodule

// File: tb/tb_prbs31_lock_checker.sv
// Scoreboard bench for prbs31_lock_checker: the driver pushes the expected
// outputs for every driven cycle; the monitor pops and compares one entry
// just after each rising edge.
module tb_prbs31_lock_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_in;
    logic        data_in_valid;
    logic        locked;
    logic [31:0] total_bits;
    logic [31:0] total_bit_errors;
    logic [15:0] relock_count;
    logic        error_pulse;
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
    logic [31:0] last_error_pos;
`endif

    always #5 clk = ~clk;

    prbs31_lock_checker dut (
        .clk              (clk),
        .rst              (rst),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .locked           (locked),
        .total_bits       (total_bits),
        .total_bit_errors (total_bit_errors),
        .relock_count     (relock_count),
        .error_pulse      (error_pulse)
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
        ,
        .last_error_pos   (last_error_pos)
`endif
    );

    typedef struct packed {
        logic        lk;
        logic [31:0] tb;
        logic [31:0] te;
        logic [15:0] rc;
        logic        ep;
        logic [31:0] lep;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [30:0] gen_r;

    // Expected outputs, maintained by the scenario code.
    logic        exp_lk;
    logic [31:0] exp_tb;
    logic [31:0] exp_te;
    logic [15:0] exp_rc;
    logic        exp_ep;
    logic [31:0] exp_lep;
    int          acq;       // valid bits since the last (re)seed while unlocked

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry per driven cycle, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("locked",           {31'd0, locked},      {31'd0, mon_e.lk});
            chk("total_bits",       total_bits,           mon_e.tb);
            chk("total_bit_errors", total_bit_errors,     mon_e.te);
            chk("relock_count",     {16'd0, relock_count}, {16'd0, mon_e.rc});
            chk("error_pulse",      {31'd0, error_pulse}, {31'd0, mon_e.ep});
`ifdef PRBS_LOCK_CHECKER_ERR_POS_EN
            chk("last_error_pos",   last_error_pos,       mon_e.lep);
`endif
        end
    end

    // Drive one cycle and push the expectation for the edge that samples it.
    task automatic drive(input logic v, input logic flip, input logic r);
        logic b;
        exp_t e;
        @(negedge clk);
        rst           = r;
        data_in_valid = v;
        if (v && !r) begin
            b       = gen_r[30] ^ gen_r[27];
            gen_r   = {gen_r[29:0], b};
            data_in = b ^ flip;
        end else begin
            data_in = 1'($urandom_range(0, 1));
        end
        e.lk  = exp_lk;
        e.tb  = exp_tb;
        e.te  = exp_te;
        e.rc  = exp_rc;
        e.ep  = exp_ep;
        e.lep = exp_lep;
        sb_q.push_back(e);
    endtask

    // One valid bit; 'flip' corrupts it, 'lose' marks the bit known to drop lock.
    task automatic vbit(input logic flip, input logic lose);
        exp_ep = 1'b0;
        if (exp_lk) begin
            exp_tb = exp_tb + 32'd1;
            if (flip) begin
                exp_te  = exp_te + 32'd1;
                exp_ep  = 1'b1;
                exp_lep = exp_tb;
            end
            if (lose) begin
                exp_lk = 1'b0;
                exp_rc = exp_rc + 16'd1;
                acq    = 0;
            end
        end else begin
            acq = acq + 1;
            if (acq == 95) exp_lk = 1'b1;
        end
        drive(1'b1, flip, 1'b0);
    endtask

    task automatic ibit();
        exp_ep = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic v);
        exp_lk  = 1'b0;
        exp_tb  = 32'd0;
        exp_te  = 32'd0;
        exp_rc  = 16'd0;
        exp_ep  = 1'b0;
        exp_lep = 32'd0;
        acq     = 0;
        drive(v, 1'b0, 1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        data_in       = 1'b0;
        data_in_valid = 1'b0;
        gen_r         = 31'h7FFF_FFFF;

        do_reset(1'b0);

        // Clean stream: lock after bit 95, 105 locked bits, no errors.
        for (int i = 1; i <= 200; i++) vbit(1'b0, 1'b0);

        // Reset together with valid: reset wins.
        do_reset(1'b1);

        // One flipped bit in 100, then 50 clean bits.
        for (int i = 1; i <= 100; i++) vbit(1'b0, 1'b0);
        for (int i = 1; i <= 100; i++) vbit(i == 50, 1'b0);
        for (int i = 1; i <= 50; i++)  vbit(1'b0, 1'b0);

        // Eight errors in the first window (locked bits 5..40): loss, then relock.
        do_reset(1'b0);
        for (int i = 1; i <= 95; i++)  vbit(1'b0, 1'b0);
        for (int i = 1; i <= 40; i++)  vbit((i % 5) == 0, i == 40);
        for (int i = 1; i <= 105; i++) vbit(1'b0, 1'b0);

        // Seven errors ending on bit 128, seven starting on bit 129: stays locked.
        do_reset(1'b0);
        for (int i = 1; i <= 95; i++)  vbit(1'b0, 1'b0);
        for (int i = 1; i <= 260; i++) vbit((i >= 122) && (i <= 135), 1'b0);

        // Eighth error on the window's last bit: loss takes priority.
        do_reset(1'b0);
        for (int i = 1; i <= 95; i++)  vbit(1'b0, 1'b0);
        for (int i = 1; i <= 128; i++) vbit(i >= 121, i == 128);
        for (int i = 1; i <= 100; i++) vbit(1'b0, 1'b0);

        // Valid toggling every cycle: same lock point in valid bits.
        do_reset(1'b0);
        for (int i = 1; i <= 200; i++) begin
            vbit(i == 150, 1'b0);
            ibit();
        end

        // Reset while locked with total_bits = 500.
        do_reset(1'b0);
        for (int i = 1; i <= 95; i++)  vbit(1'b0, 1'b0);
        for (int i = 1; i <= 500; i++) vbit(i == 250, 1'b0);
        do_reset(1'b1);
        for (int i = 1; i <= 3; i++)   vbit(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
